// File: rtl/bpsk_demodulator_if.sv
// rtl/bpsk_demodulator_if.sv - sample/symbol interface for the BPSK demodulator
interface bpsk_demodulator_if;
    logic               in_valid;
    logic signed [15:0] mod_in;
    logic        [7:0]  cos_in;
    logic               sym_sync;
    logic               bit_valid;
    logic               bit_out;
    logic signed [15:0] soft_out;
    logic               locked;
    logic               sync_err;

    modport master (
        output in_valid, mod_in, cos_in, sym_sync,
        input  bit_valid, bit_out, soft_out, locked, sync_err
    );

    modport slave (
        input  in_valid, mod_in, cos_in, sym_sync,
        output bit_valid, bit_out, soft_out, locked, sync_err
    );
endinterface

// File: rtl/bpsk_demodulator.sv
// rtl/bpsk_demodulator.sv - coherent BPSK mixer with integrate-and-dump per symbol
module bpsk_demodulator #(
    parameter int SPS   = 8,
    parameter int ACC_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    bpsk_demodulator_if.slave  bus
);
    localparam int CNT_W = $clog2(SPS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SPS - 1);

    typedef enum logic {WAIT_SYNC, TRACK} state_t;

    state_t                  r_state;
    logic signed [23:0]      r_prod;
    logic                    r_prod_v;
    logic                    r_prod_sync;
    logic signed [ACC_W-1:0] r_acc;
    logic        [CNT_W-1:0] r_cnt;

    logic signed [7:0]       w_cos_s;
    logic signed [23:0]      w_mod_ext;
    logic signed [23:0]      w_cos_ext;
    logic signed [23:0]      w_prod;
    logic signed [ACC_W-1:0] w_prod_ext;
    logic signed [ACC_W-1:0] w_sum;
    logic signed [15:0]      w_soft;

    // Offset-binary to two's complement is just an MSB flip.
    assign w_cos_s    = $signed(bus.cos_in ^ 8'h80);
    assign w_mod_ext  = {{8{bus.mod_in[15]}}, bus.mod_in};
    assign w_cos_ext  = {{16{w_cos_s[7]}}, w_cos_s};
    assign w_prod     = w_mod_ext * w_cos_ext;
    assign w_prod_ext = {{(ACC_W-24){r_prod[23]}}, r_prod};
    assign w_sum      = r_acc + w_prod_ext;
    assign w_soft     = 16'(w_sum >>> (ACC_W - 16));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= WAIT_SYNC;
            r_prod        <= '0;
            r_prod_v      <= 1'b0;
            r_prod_sync   <= 1'b0;
            r_acc         <= '0;
            r_cnt         <= '0;
            bus.bit_valid <= 1'b0;
            bus.bit_out   <= 1'b0;
            bus.soft_out  <= '0;
            bus.locked    <= 1'b0;
            bus.sync_err  <= 1'b0;
        end else begin
            r_prod        <= w_prod;
            r_prod_v      <= bus.in_valid;
            r_prod_sync   <= bus.in_valid & bus.sym_sync;
            bus.bit_valid <= 1'b0;
            bus.sync_err  <= 1'b0;
            if (r_prod_v) begin
                case (r_state)
                    WAIT_SYNC: begin
                        if (r_prod_sync) begin
                            r_state    <= TRACK;
                            bus.locked <= 1'b1;
                            r_acc      <= w_prod_ext;
                            r_cnt      <= CNT_W'(1);
                        end
                    end
                    TRACK: begin
                        // A sync mid-symbol abandons the partial sum; at cnt 0 it is a plain sample.
                        if (r_prod_sync && r_cnt != '0) begin
                            bus.sync_err <= 1'b1;
                            r_acc        <= w_prod_ext;
                            r_cnt        <= CNT_W'(1);
                        end else if (r_cnt == LAST) begin
                            bus.bit_valid <= 1'b1;
                            bus.bit_out   <= ~w_sum[ACC_W-1];
                            bus.soft_out  <= w_soft;
                            r_acc         <= '0;
                            r_cnt         <= '0;
                        end else begin
                            r_acc <= w_sum;
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: r_state <= WAIT_SYNC;
                endcase
            end
        end
    end
endmodule
